// File: rtl/load_store_unit.sv
// load_store_unit: sequences CPU byte/halfword/word loads and stores onto a
// single-ported word memory. Sub-word stores use read-modify-write, and
// misaligned or illegal requests are answered without touching memory.
module load_store_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic              r_we;
  logic [2:0]        r_funct3;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic [31:0]       r_rdword;
  logic              r_err;

  logic              w_accept;
  logic              w_req_err;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load_ext;
  logic [31:0]       w_merged;

  assign w_accept = req_valid && (r_state == IDLE);

  // Classify the incoming request as misaligned/illegal so IDLE can route it straight to RESP
  always_comb begin
    w_req_err = 1'b0;
    if (req_we) begin
      case (req_funct3)
        3'b000:  w_req_err = 1'b0;
        3'b001:  w_req_err = req_addr[0];
        3'b010:  w_req_err = |req_addr[1:0];
        default: w_req_err = 1'b1;  // 011 and anything with bit 2 set has no store meaning
      endcase
    end else begin
      case (req_funct3)
        3'b000:  w_req_err = 1'b0;
        3'b100:  w_req_err = 1'b0;
        3'b001:  w_req_err = req_addr[0];
        3'b101:  w_req_err = req_addr[0];
        3'b010:  w_req_err = |req_addr[1:0];
        default: w_req_err = 1'b1;
      endcase
    end
  end

  // Pick the addressed lane from the memory word and sign/zero extend it
  always_comb begin
    w_byte     = mem_read_data[{r_addr[1:0], 3'b000} +: 8];
    w_half     = r_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    w_load_ext = '0;
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b010:  w_load_ext = mem_read_data;
      3'b100:  w_load_ext = {24'd0, w_byte};
      3'b101:  w_load_ext = {16'd0, w_half};
      default: w_load_ext = '0;
    endcase
  end

  // Splice the store data into the previously read word; SW bypasses the merge
  always_comb begin
    w_merged = r_rdword;
    case (r_funct3)
      3'b000: w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      3'b001: begin
        if (r_addr[1]) w_merged[31:16] = r_wdata[15:0];
        else           w_merged[15:0]  = r_wdata[15:0];
      end
      default: w_merged = r_wdata;
    endcase
  end

  // State register; asynchronous reset drops any in-flight access immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Capture the request on accept and hold the load result / RMW read word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_rdword <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_err    <= w_req_err;
        r_rdata  <= '0;  // stores and errors answer with zero data
      end
      if (r_state == LOAD)   r_rdata  <= w_load_ext;
      if (r_state == RMW_RD) r_rdword <= mem_read_data;
    end
  end

  // Next-state decode; all outputs are pure functions of state so reset clears them at once
  always_comb begin
    w_state_next   = r_state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_rdata     = '0;
    resp_err       = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_err)                 w_state_next = RESP;
          else if (!req_we)              w_state_next = LOAD;
          else if (req_funct3 == 3'b010) w_state_next = WRITE;
          else                           w_state_next = RMW_RD;
        end
      end
      LOAD: begin
        mem_read     = 1'b1;
        mem_address  = r_addr[ADDR_W+1:2];
        w_state_next = RESP;
      end
      RMW_RD: begin
        mem_read     = 1'b1;
        mem_address  = r_addr[ADDR_W+1:2];
        w_state_next = WRITE;
      end
      WRITE: begin
        mem_write      = 1'b1;
        mem_address    = r_addr[ADDR_W+1:2];
        mem_write_data = w_merged;
        w_state_next   = RESP;
      end
      RESP: begin
        resp_valid   = 1'b1;
        resp_rdata   = r_rdata;
        resp_err     = r_err;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of the load/store unit against a
// behavioural word memory, with a response scoreboard and latency tracking.
module tb_load_store_unit;
  localparam int ADDR_W = 10;
  localparam int LOGN   = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = '0;
  logic [ADDR_W+1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Behavioural data memory: combinational read, write on rising edge
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  assign mem_read_data = mem[mem_address];
  always @(posedge clk) if (mem_write) mem[mem_address] <= mem_write_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event logs written only by the monitor
  logic [31:0] resp_rdata_log [LOGN];
  logic        resp_err_log   [LOGN];
  int          resp_cyc_log   [LOGN];
  int          acc_cyc_log    [LOGN];
  int n_resp = 0, n_acc = 0, rd_cycles = 0, wr_cycles = 0, viol = 0;

  always @(negedge clk) begin
    if (rst_n && req_valid && req_ready && n_acc < LOGN) begin
      acc_cyc_log[n_acc] <= cyc + 1;
      n_acc <= n_acc + 1;
    end
    if (resp_valid && n_resp < LOGN) begin
      resp_rdata_log[n_resp] <= resp_rdata;
      resp_err_log[n_resp]   <= resp_err;
      resp_cyc_log[n_resp]   <= cyc;
      n_resp <= n_resp + 1;
    end
    if (mem_read)  rd_cycles <= rd_cycles + 1;
    if (mem_write) wr_cycles <= wr_cycles + 1;
    if ((mem_read && mem_write) ||
        (!mem_read && !mem_write && (mem_address != '0 || mem_write_data != '0)))
      viol <= viol + 1;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t  exp_q [$];
  string tag_q [$];
  int n_checks = 0, n_errors = 0;
  int resp_rd = 0, acc_rd = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_resp(input string tag, input logic [31:0] rdata, input logic err, input int lat);
    exp_t e;
    e.rdata = rdata; e.err = err; e.lat = lat;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Present a request and hold it until the unit takes it; returns at posedge+1 after accept
  task automatic issue(input logic we, input logic [2:0] f3, input logic [ADDR_W+1:0] addr,
                       input logic [31:0] wdata);
    bit got = 0;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin got = 1; break; end
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  // Pop every outstanding expectation against the logged responses
  task automatic drain();
    exp_t  e;
    string t;
    while (exp_q.size() > 0) begin
      bit got = 0;
      for (int i = 0; i < 30; i++) begin
        if (n_resp > resp_rd) begin got = 1; break; end
        @(negedge clk); #1;
      end
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (!got) begin
        check({t, "_resp_timeout"}, 32'd0, 32'd1);
      end else begin
        check({t, "_rdata"}, resp_rdata_log[resp_rd], e.rdata);
        check({t, "_err"}, {31'd0, resp_err_log[resp_rd]}, {31'd0, e.err});
        check({t, "_latency"}, resp_cyc_log[resp_rd] - acc_cyc_log[acc_rd] + 1, e.lat);
        resp_rd++;
        acc_rd++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic op(input string tag, input logic we, input logic [2:0] f3,
                    input logic [ADDR_W+1:0] addr, input logic [31:0] wdata,
                    input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    expect_resp(tag, exp_rdata, exp_err, lat);
    issue(we, f3, addr, wdata);
    req_valid = 1'b0;
    drain();
    $display("txn %s we=%0b f3=%03b addr=0x%03h wdata=0x%08h exp=0x%08h err=%0b",
             tag, we, f3, addr, wdata, exp_rdata, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, wr0, c0, nr0, na0;

    // Reset values while rst_n is low
    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_mem_addr", {22'd0, mem_address}, 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // SW then LW, first request taken on the first edge after reset release
    c0 = cyc; rd0 = rd_cycles; wr0 = wr_cycles;
    op("sw_010", 1'b1, 3'b010, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    check("first_accept_cycle", acc_cyc_log[0], c0 + 1);
    check("sw_mem_word4", mem[4], 32'hDEADBEEF);
    check("sw_wr_count", wr_cycles - wr0, 32'd1);
    check("sw_rd_count", rd_cycles - rd0, 32'd0);
    op("lw_010", 1'b0, 3'b010, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // SB read-modify-write
    rd0 = rd_cycles; wr0 = wr_cycles;
    op("sb_011", 1'b1, 3'b000, 12'h011, 32'hFFFFFF55, 32'h0, 1'b0, 3);
    check("sb_rd_count", rd_cycles - rd0, 32'd1);
    check("sb_wr_count", wr_cycles - wr0, 32'd1);
    op("lw_after_sb", 1'b0, 3'b010, 12'h010, 32'h0, 32'hDEAD55EF, 1'b0, 2);

    // Extension of byte/halfword loads
    op("sw_pattern", 1'b1, 3'b010, 12'h010, 32'h80FF7F01, 32'h0, 1'b0, 2);
    op("lb_013", 1'b0, 3'b000, 12'h013, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    op("lbu_013", 1'b0, 3'b100, 12'h013, 32'h0, 32'h00000080, 1'b0, 2);
    op("lh_012", 1'b0, 3'b001, 12'h012, 32'h0, 32'hFFFF80FF, 1'b0, 2);
    op("lhu_010", 1'b0, 3'b101, 12'h010, 32'h0, 32'h00007F01, 1'b0, 2);
    op("lb_010", 1'b0, 3'b000, 12'h010, 32'h0, 32'h00000001, 1'b0, 2);
    op("lb_012", 1'b0, 3'b000, 12'h012, 32'h0, 32'hFFFFFFFF, 1'b0, 2);
    op("lb_011", 1'b0, 3'b000, 12'h011, 32'h0, 32'h0000007F, 1'b0, 2);

    // SH on the upper halfword keeps the lower half intact
    op("sh_012", 1'b1, 3'b001, 12'h012, 32'hABCD1234, 32'h0, 1'b0, 3);
    op("lw_after_sh", 1'b0, 3'b010, 12'h010, 32'h0, 32'h12347F01, 1'b0, 2);

    // Misaligned and illegal requests never reach memory
    rd0 = rd_cycles; wr0 = wr_cycles;
    op("err_lw_012", 1'b0, 3'b010, 12'h012, 32'h0, 32'h0, 1'b1, 1);
    op("err_sh_011", 1'b1, 3'b001, 12'h011, 32'h0000BEEF, 32'h0, 1'b1, 1);
    op("err_ld_f011", 1'b0, 3'b011, 12'h010, 32'h0, 32'h0, 1'b1, 1);
    op("err_lhu_013", 1'b0, 3'b101, 12'h013, 32'h0, 32'h0, 1'b1, 1);
    op("err_st_f100", 1'b1, 3'b100, 12'h010, 32'h11111111, 32'h0, 1'b1, 1);
    op("err_sw_011", 1'b1, 3'b010, 12'h011, 32'h22222222, 32'h0, 1'b1, 1);
    check("err_rd_count", rd_cycles - rd0, 32'd0);
    check("err_wr_count", wr_cycles - wr0, 32'd0);
    check("err_word4_kept", mem[4], 32'h12347F01);

    // Top of the address space is an ordinary word
    op("sw_ffc", 1'b1, 3'b010, 12'hFFC, 32'hCAFEF00D, 32'h0, 1'b0, 2);
    check("top_mem_word", mem[1023], 32'hCAFEF00D);
    op("lbu_fff", 1'b0, 3'b100, 12'hFFF, 32'h0, 32'h000000CA, 1'b0, 2);
    op("lb_ffe", 1'b0, 3'b000, 12'hFFE, 32'h0, 32'hFFFFFFFE, 1'b0, 2);

    // Reset asserted mid-cycle during WRITE aborts the store with no response
    op("sw_020_init", 1'b1, 3'b010, 12'h020, 32'hA5A5A5A5, 32'h0, 1'b0, 2);
    nr0 = n_resp;
    issue(1'b1, 3'b010, 12'h020, 32'h12345678);
    req_valid = 1'b0;
    check("abort_in_write", {31'd0, mem_write}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_mem_write_low", {31'd0, mem_write}, 32'd0);
    check("abort_mem_addr", {22'd0, mem_address}, 32'd0);
    check("abort_mem_wdata", mem_write_data, 32'd0);
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    check("abort_word8_kept", mem[8], 32'hA5A5A5A5);
    acc_rd++;  // the aborted store was accepted but never answers
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("abort_no_resp", n_resp - nr0, 32'd0);
    $display("txn abort_sw_020 reset during WRITE, word8=0x%08h", mem[8]);
    op("lw_020", 1'b0, 3'b010, 12'h020, 32'h0, 32'hA5A5A5A5, 1'b0, 2);

    // Four loads with req_valid held high across busy cycles
    nr0 = n_resp; na0 = n_acc;
    expect_resp("b2b_0", 32'h12347F01, 1'b0, 2);
    expect_resp("b2b_1", 32'hA5A5A5A5, 1'b0, 2);
    expect_resp("b2b_2", 32'h000000CA, 1'b0, 2);
    expect_resp("b2b_3", 32'hCAFEF00D, 1'b0, 2);
    issue(1'b0, 3'b010, 12'h010, 32'h0);
    issue(1'b0, 3'b010, 12'h020, 32'h0);
    issue(1'b0, 3'b100, 12'hFFF, 32'h0);
    issue(1'b0, 3'b010, 12'hFFC, 32'h0);
    req_valid = 1'b0;
    drain();
    repeat (4) begin @(posedge clk); #1; end
    check("b2b_accepts", n_acc - na0, 32'd4);
    check("b2b_responses", n_resp - nr0, 32'd4);
    $display("txn b2b four held loads, responses=%0d", n_resp - nr0);

    check("rw_exclusive_and_idle_zero", viol, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_W, default 10, word-address width presented to data memory (byte address = ADDR_W+2 bits).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  CPU access request present.
REQ-005 req_ready  output  1  unit can accept a request (high only in IDLE).
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RISC-V width code: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-008 req_addr  input  ADDR_W+2  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-012 resp_err  output  1  misaligned or illegal request, valid with resp_valid.
REQ-013 mem_read  output  1  drives data-memory read enable.
REQ-014 mem_write  output  1  drives data-memory write enable (memory writes on rising edge).
REQ-015 mem_address  output  ADDR_W  word address = captured req_addr[ADDR_W+1:2].
REQ-016 mem_write_data  output  32  full word to write.
REQ-017 mem_read_data  input  32  combinational word read from memory.

Function
REQ-018 The unit SHALL capture req_we, req_funct3, req_addr and req_wdata on the rising edge where req_valid && req_ready, and ignore request inputs otherwise.
REQ-019 FSM states SHALL be IDLE, LOAD, RMW_RD, WRITE, RESP; reset state IDLE.
REQ-020 From IDLE on accept: error -> RESP; load -> LOAD; SW -> WRITE; SB/SH -> RMW_RD.
REQ-021 LOAD SHALL assert mem_read for exactly one cycle, latch the extracted result, and go to RESP.
REQ-022 RMW_RD SHALL assert mem_read for one cycle, latch mem_read_data, and go to WRITE.
REQ-023 WRITE SHALL assert mem_write for exactly one cycle with the merged word, then go to RESP.
REQ-024 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE.
REQ-025 mem_read and mem_write SHALL never be high in the same cycle; mem_address and mem_write_data SHALL be 0 when both are low.
REQ-026 Byte lane = addr[1:0] (lane 0 = bits 7:0); halfword lane = addr[1] (0 = bits 15:0).
REQ-027 LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, LW SHALL return the word unchanged.
REQ-028 SB/SH SHALL replace only the addressed byte/halfword of the read word with req_wdata[7:0]/[15:0]; other bits SHALL be preserved.
REQ-029 Error SHALL be flagged for LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=00, load funct3 011/110/111, store funct3 with bit 2 set; errored requests SHALL perform no memory access.
REQ-030 Latency from accept edge to resp_valid: error 1 cycle, load/SW 2 cycles, SB/SH 3 cycles.
REQ-031 req_ready SHALL be 0 in every state except IDLE; a request held through busy cycles SHALL be accepted on the first IDLE cycle.
REQ-032 Address wrap is not supported: the top byte address (all ones) is a normal word in the last memory location.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0.
REQ-034 Reset asserted during WRITE SHALL deassert mem_write before the next clock edge so no write occurs; the pending request SHALL be discarded with no response.
REQ-035 After rst_n rises, the first request SHALL be accepted on the first clk edge with req_valid=1.

Verification
REQ-036 SW addr 0x010 data 0xDEADBEEF, then LW addr 0x010 -> one mem_write at word 4, later resp_rdata=0xDEADBEEF, resp_err=0, load latency 2.
REQ-037 Word 4 = 0xDEADBEEF; SB addr 0x011 data 0x55; LW 0x010 -> 0xDEAD55EF; SB latency 3; exactly one mem_read then one mem_write.
REQ-038 Word 4 = 0x80FF7F01; LB 0x012 -> 0xFFFFFFFF... use LB 0x013 -> 0xFFFFFF80, LBU 0x013 -> 0x00000080, LH 0x012 -> 0xFFFF80FF, LHU 0x010 -> 0x00007F01.
REQ-039 LW addr 0x012, SH addr 0x011, load funct3 011 -> each resp_err=1, resp_rdata=0, latency 1, mem_read/mem_write never asserted.
REQ-040 Assert rst_n=0 mid-cycle during WRITE of SW 0x020/0x12345678 -> mem_write drops immediately, word 8 unchanged, no resp_valid, req_ready=1.
REQ-041 Back-to-back held req_valid for 4 loads -> each accepted only when req_ready=1, four resp_valid pulses in order, no lost or duplicated requests.
